// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
// Branch prediction and control-hazard unit for an in-order pipeline.
// A table of 2-bit saturating counters predicts branches seen in IF; the
// branch in EX is resolved from the ALU flags, trains the table, and on a
// mispredict redirects fetch and squashes IF/ID and ID/EX in the same cycle.
// A one-state RECOVER phase then ignores the squashed EX slot.

module branch_hazard_ctrl #(
  parameter int XLEN  = 64,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_is_branch,
  input  logic            ex_branch,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_zero,
  input  logic            ex_pos,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            pred_taken,
  output logic [1:0]      pc_sel,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  // Counter encodings: 00/01 predict not-taken, 10/11 predict taken.
  localparam logic [1:0] CTR_INIT = 2'b01;
  localparam logic [1:0] CTR_MAX  = 2'b11;
  localparam logic [1:0] CTR_MIN  = 2'b00;

  localparam logic [1:0] SEL_SEQ      = 2'b00;
  localparam logic [1:0] SEL_PREDICT  = 2'b01;
  localparam logic [1:0] SEL_REDIRECT = 2'b10;

  typedef enum logic {
    IDLE,
    RECOVER
  } state_t;

  state_t           state;
  logic [1:0]       bht [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             funct3_valid;
  logic             actual_taken;
  logic             resolve;
  logic             mispredict;
  logic [XLEN-1:0]  fallthrough_pc;

  // Only the word-index bits of the fetch PC select a table entry.
  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  assign if_idx         = if_pc[IDX_W+1:2];
  assign ex_idx         = ex_pc[IDX_W+1:2];
  assign fallthrough_pc = ex_pc + XLEN'(4);

  // Decode the EX branch condition from funct3 and the rs1-rs2 flags.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    funct3_valid = 1'b0;
    actual_taken = 1'b0;
    unique case (ex_funct3)
      3'b000: begin funct3_valid = 1'b1; actual_taken = ex_zero;             end
      3'b001: begin funct3_valid = 1'b1; actual_taken = ~ex_zero;            end
      3'b100: begin funct3_valid = 1'b1; actual_taken = ~ex_pos & ~ex_zero;  end
      3'b101: begin funct3_valid = 1'b1; actual_taken = ex_pos | ex_zero;    end
      default: ;
    endcase
  end

  // A resolve cycle trains the table and counters; the RECOVER slot holds a
  // squashed instruction and a stalled cycle defers resolution.
  assign resolve    = ~reset & (state == IDLE) & ex_branch & ~stall & funct3_valid;
  assign mispredict = resolve & (actual_taken != ex_pred_taken);

  // Fetch steering: a redirect outranks the IF prediction; a stall freezes fetch.
  always_comb begin
    pred_taken  = ~reset & if_is_branch & bht[if_idx][1];
    pc_sel      = SEL_SEQ;
    redirect_pc = '0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    if (mispredict) begin
      pc_sel      = SEL_REDIRECT;
      redirect_pc = actual_taken ? ex_target : fallthrough_pc;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
    end else if (!stall && pred_taken) begin
      pc_sel = SEL_PREDICT;
    end
  end

  // Branch history table: reset to weakly not-taken, saturating training.
  always_ff @(posedge clk) begin
    // NOTE: the table is a register array with a reset loop rather than a
    // RAM, because every entry must come out of reset at a known value.
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= CTR_INIT;
      end
    end else if (resolve) begin
      if (actual_taken) begin
        if (bht[ex_idx] != CTR_MAX) bht[ex_idx] <= bht[ex_idx] + 2'd1;
      end else begin
        if (bht[ex_idx] != CTR_MIN) bht[ex_idx] <= bht[ex_idx] - 2'd1;
      end
    end
  end

  // Recovery FSM: one unstalled cycle in RECOVER skips the squashed EX slot.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state <= IDLE;
    end else if (!stall) begin
      unique case (state)
        IDLE:    if (mispredict) state <= RECOVER;
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Performance counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve && branch_cnt != '1)     branch_cnt  <= branch_cnt + 32'd1;
      if (mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl
// Directed scenarios plus a randomized run, all checked against a
// behavioural model of the predictor kept in this bench.

module tb_branch_hazard_ctrl;

  localparam int XLEN  = 64;
  localparam int IDX_W = 4;
  localparam int N     = 1 << IDX_W;

  logic            clk;
  logic            reset;
  logic            stall;
  logic [XLEN-1:0] if_pc;
  logic            if_is_branch;
  logic            ex_branch;
  logic [2:0]      ex_funct3;
  logic            ex_zero;
  logic            ex_pos;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic            pred_taken;
  logic [1:0]      pc_sel;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_ifid;
  logic            flush_idex;
  logic [31:0]     branch_cnt;
  logic [31:0]     mispred_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_bht [N];
  bit          m_recover;
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  branch_hazard_ctrl #(.XLEN(XLEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .if_pc(if_pc), .if_is_branch(if_is_branch),
    .ex_branch(ex_branch), .ex_funct3(ex_funct3),
    .ex_zero(ex_zero), .ex_pos(ex_pos),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .pred_taken(pred_taken), .pc_sel(pc_sel), .redirect_pc(redirect_pc),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx_of(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % N);
  endfunction

  // Branch rules: which funct3 values are branches and whether they are taken.
  function automatic void rule(output bit valid, output bit taken);
    valid = 1'b1;
    case (ex_funct3)
      3'd0: taken = ex_zero;
      3'd1: taken = !ex_zero;
      3'd4: taken = !ex_zero && !ex_pos;
      3'd5: taken = ex_zero || ex_pos;
      default: begin valid = 1'b0; taken = 1'b0; end
    endcase
  endfunction

  // Expected combinational outputs for the current inputs and model state.
  function automatic void expect_out(output bit e_pred, output bit [1:0] e_sel,
                                     output bit e_flush, output logic [XLEN-1:0] e_redir);
    bit v, t, resolving;
    rule(v, t);
    e_pred    = !reset && if_is_branch && (m_bht[idx_of(if_pc)] >= 2);
    resolving = !reset && !m_recover && ex_branch && !stall && v;
    e_flush   = resolving && (t != ex_pred_taken);
    e_redir   = e_flush ? (t ? ex_target : ex_pc + 64'd4) : '0;
    if (e_flush)              e_sel = 2'd2;
    else if (!stall && e_pred) e_sel = 2'd1;
    else                      e_sel = 2'd0;
  endfunction

  // Advance the model by one clock edge, then let the DUT take the same edge.
  task automatic tick();
    bit v, t;
    int i;
    rule(v, t);
    if (reset) begin
      for (int k = 0; k < N; k++) m_bht[k] = 1;
      m_recover = 1'b0;
      m_bcnt = 0;
      m_mcnt = 0;
    end else if (!stall) begin
      if (m_recover) begin
        m_recover = 1'b0;
      end else if (ex_branch && v) begin
        i = idx_of(ex_pc);
        m_bht[i] = t ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3)
                     : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
        if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
        if (t != ex_pred_taken) begin
          if (m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
          m_recover = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; if_pc = '0; if_is_branch = 0;
    ex_branch = 0; ex_funct3 = 3'd2; ex_zero = 0; ex_pos = 0;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic set_branch(input logic [2:0] f3, input bit z, input bit p,
                            input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                            input bit pred);
    ex_branch = 1; ex_funct3 = f3; ex_zero = z; ex_pos = p;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; if_is_branch = 1; if_pc = 64'h0000_0000_0000_0040;
    set_branch(3'd0, 1, 0, 64'h100, 64'h180, 0);
    #1;
    checks++;
    if ({pred_taken, pc_sel, flush_ifid, flush_idex} !== 5'b0 || redirect_pc !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got pred=%0b sel=%0b fl=%0b%0b redir=%h, want all 0",
               pred_taken, pc_sel, flush_ifid, flush_idex, redirect_pc);
    end
    tick(); tick();
    reset = 0; ex_branch = 0; if_pc = 64'h1234_5678;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pc_sel !== 2'b00) begin
      failures++;
      $display("FAIL reset_predict: got pred=%0b sel=%0b, want 0 00", pred_taken, pc_sel);
    end
    checks++;
    if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters: got b=%0d m=%0d, want 0 0", branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_beq_mispredict();
    do_reset();
    set_branch(3'd0, 1, 0, 64'h100, 64'h180, 0);
    #1;
    checks++;
    if (pc_sel !== 2'b10 || redirect_pc !== 64'h180 || {flush_ifid, flush_idex} !== 2'b11) begin
      failures++;
      $display("FAIL beq_redirect: got sel=%0b redir=%h fl=%0b%0b, want 10 180 11",
               pc_sel, redirect_pc, flush_ifid, flush_idex);
    end
    tick();
    checks++;
    if (mispred_cnt !== 32'd1 || branch_cnt !== 32'd1) begin
      failures++;
      $display("FAIL beq_counters: got b=%0d m=%0d, want 1 1", branch_cnt, mispred_cnt);
    end
    // RECOVER slot: EX branch ignored, IF sees BHT[0]=10 (taken)
    if_pc = 64'h100; if_is_branch = 1;
    #1;
    checks++;
    if ({flush_ifid, flush_idex} !== 2'b00 || pc_sel !== 2'b01 || pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL beq_recover: got fl=%0b%0b sel=%0b pred=%0b, want 00 01 1",
               flush_ifid, flush_idex, pc_sel, pred_taken);
    end
    tick();
    checks++;
    if (mispred_cnt !== 32'd1 || branch_cnt !== 32'd1) begin
      failures++;
      $display("FAIL beq_recover_cnt: got b=%0d m=%0d, want 1 1", branch_cnt, mispred_cnt);
    end
    #1;
    checks++;
    if ({flush_ifid, flush_idex} !== 2'b11) begin
      failures++;
      $display("FAIL beq_back_to_idle: got fl=%0b%0b, want 11", flush_ifid, flush_idex);
    end
    idle_inputs();
  endtask

  task automatic test_bne_saturate();
    do_reset();
    if_pc = 64'h40; if_is_branch = 1;
    set_branch(3'd1, 0, 1, 64'h40, 64'h80, 1);
    #1;
    // Same-index read during the write returns the pre-update value (01).
    checks++;
    if (pred_taken !== 1'b0 || flush_ifid !== 1'b0) begin
      failures++;
      $display("FAIL bne_no_bypass: got pred=%0b fl=%0b, want 0 0", pred_taken, flush_ifid);
    end
    for (int n = 0; n < 3; n++) tick();
    ex_branch = 0;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pc_sel !== 2'b01) begin
      failures++;
      $display("FAIL bne_predict: got pred=%0b sel=%0b, want 1 01", pred_taken, pc_sel);
    end
    checks++;
    if (branch_cnt !== 32'd3 || mispred_cnt !== 32'd0) begin
      failures++;
      $display("FAIL bne_counters: got b=%0d m=%0d, want 3 0", branch_cnt, mispred_cnt);
    end
    // Two not-taken from a saturated 11: 10 still taken, then 01 not taken.
    set_branch(3'd1, 1, 0, 64'h40, 64'h80, 0);
    tick();
    ex_branch = 0;
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL bne_saturated: got pred=%0b, want 1", pred_taken);
    end
    ex_branch = 1;
    tick();
    ex_branch = 0;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL bne_decay: got pred=%0b, want 0", pred_taken);
    end
    idle_inputs();
  endtask

  task automatic test_bge_wrap();
    do_reset();
    set_branch(3'd5, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 1);
    #1;
    checks++;
    if (pc_sel !== 2'b10 || redirect_pc !== 64'h0 || flush_idex !== 1'b1) begin
      failures++;
      $display("FAIL bge_wrap: got sel=%0b redir=%h fl=%0b, want 10 0 1",
               pc_sel, redirect_pc, flush_idex);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_stall_defer();
    do_reset();
    if_pc = 64'h1000; if_is_branch = 1;
    set_branch(3'd4, 0, 0, 64'h1000, 64'h2000, 0);
    stall = 1;
    for (int n = 0; n < 2; n++) begin
      #1;
      checks++;
      if (pc_sel !== 2'b00 || {flush_ifid, flush_idex} !== 2'b00 || pred_taken !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: got sel=%0b fl=%0b%0b pred=%0b, want 00 00 0",
                 n, pc_sel, flush_ifid, flush_idex, pred_taken);
      end
      tick();
      checks++;
      if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
        failures++;
        $display("FAIL stall_cnt%0d: got b=%0d m=%0d, want 0 0", n, branch_cnt, mispred_cnt);
      end
    end
    stall = 0;
    #1;
    checks++;
    if (pc_sel !== 2'b10 || redirect_pc !== 64'h2000 || {flush_ifid, flush_idex} !== 2'b11) begin
      failures++;
      $display("FAIL stall_release: got sel=%0b redir=%h fl=%0b%0b, want 10 2000 11",
               pc_sel, redirect_pc, flush_ifid, flush_idex);
    end
    tick();
    ex_branch = 0;
    #1;
    checks++;
    if (mispred_cnt !== 32'd1 || branch_cnt !== 32'd1 || pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL stall_after: got b=%0d m=%0d pred=%0b, want 1 1 1",
               branch_cnt, mispred_cnt, pred_taken);
    end
    idle_inputs();
  endtask

  task automatic test_invalid_and_reset_recover();
    do_reset();
    set_branch(3'd2, 1, 0, 64'h200, 64'h300, 1);
    #1;
    checks++;
    if ({flush_ifid, flush_idex} !== 2'b00 || pc_sel !== 2'b00) begin
      failures++;
      $display("FAIL invalid_f3: got fl=%0b%0b sel=%0b, want 00 00", flush_ifid, flush_idex, pc_sel);
    end
    tick(); tick();
    checks++;
    if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      failures++;
      $display("FAIL invalid_cnt: got b=%0d m=%0d, want 0 0", branch_cnt, mispred_cnt);
    end
    // Enter RECOVER, then reset inside it.
    set_branch(3'd0, 1, 0, 64'h200, 64'h300, 0);
    tick();
    reset = 1;
    #1;
    checks++;
    if ({pred_taken, pc_sel, flush_ifid, flush_idex} !== 5'b0 || redirect_pc !== '0) begin
      failures++;
      $display("FAIL recover_reset: got sel=%0b fl=%0b%0b redir=%h, want 00 00 0",
               pc_sel, flush_ifid, flush_idex, redirect_pc);
    end
    tick();
    reset = 0;
    #1;
    // Back in IDLE: the same mispredicting branch resolves immediately.
    checks++;
    if ({flush_ifid, flush_idex} !== 2'b11 || redirect_pc !== 64'h300) begin
      failures++;
      $display("FAIL recover_reset_idle: got fl=%0b%0b redir=%h, want 11 300",
               flush_ifid, flush_idex, redirect_pc);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    bit e_pred, e_flush;
    bit [1:0] e_sel;
    logic [XLEN-1:0] e_redir;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 99) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      if_is_branch  = $urandom_range(0, 1);
      if_pc         = 64'($urandom_range(0, 31)) << 2;
      ex_branch     = ($urandom_range(0, 3) != 0);
      ex_funct3     = 3'($urandom_range(0, 7));
      ex_zero       = ($urandom_range(0, 2) == 0);
      ex_pos        = ex_zero ? 1'b0 : 1'($urandom_range(0, 1));
      ex_pc         = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                                  : 64'($urandom_range(0, 31)) << 2;
      ex_target     = {$urandom, $urandom};
      ex_pred_taken = $urandom_range(0, 1);
      #1;
      expect_out(e_pred, e_sel, e_flush, e_redir);
      checks++;
      if (pred_taken !== e_pred || pc_sel !== e_sel ||
          flush_ifid !== e_flush || flush_idex !== e_flush) begin
        failures++;
        $display("FAIL rand_ctrl@%0d: got pred=%0b sel=%0b fl=%0b%0b, want %0b %0b %0b%0b",
                 n, pred_taken, pc_sel, flush_ifid, flush_idex, e_pred, e_sel, e_flush, e_flush);
      end
      if (e_flush) begin
        checks++;
        if (redirect_pc !== e_redir) begin
          failures++;
          $display("FAIL rand_redirect@%0d: got %h, want %h", n, redirect_pc, e_redir);
        end
      end
      tick();
      checks++;
      if (branch_cnt !== m_bcnt || mispred_cnt !== m_mcnt) begin
        failures++;
        $display("FAIL rand_cnt@%0d: got b=%0d m=%0d, want %0d %0d",
                 n, branch_cnt, mispred_cnt, m_bcnt, m_mcnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_beq_mispredict();
    test_bne_saturate();
    test_bge_wrap();
    test_stall_defer();
    test_invalid_and_reset_recover();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64: PC/target width.
REQ-002 SHALL have parameter IDX_W, default 4: BHT index width (2^IDX_W two-bit counters).
REQ-003 SHALL have port clk  input  1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1: global pipeline freeze (load-use etc.).
REQ-006 SHALL have port if_pc  input  XLEN: PC of instruction in IF.
REQ-007 SHALL have port if_is_branch  input  1: IF predecode flags a conditional branch.
REQ-008 SHALL have port ex_branch  input  1: EX instruction is a conditional branch.
REQ-009 SHALL have port ex_funct3  input  3: branch funct3 of EX instruction.
REQ-010 SHALL have ports ex_zero, ex_pos  input  1 each: ALU (rs1-rs2) flags, zero and strictly positive.
REQ-011 SHALL have ports ex_pc, ex_target  input  XLEN each: EX branch PC and computed target.
REQ-012 SHALL have port ex_pred_taken  input  1: prediction carried with the EX instruction.
REQ-013 SHALL have port pred_taken  output  1: prediction for IF instruction.
REQ-014 SHALL have port pc_sel  output  2: 00 pc+4, 01 predicted target, 10 redirect_pc.
REQ-015 SHALL have port redirect_pc  output  XLEN: recovery fetch address.
REQ-016 SHALL have ports flush_ifid, flush_idex  output  1 each: squash IF/ID, ID/EX registers.
REQ-017 SHALL have ports branch_cnt, mispred_cnt  output  32 each: performance counters.

Function
REQ-018 SHALL hold a BHT of 2^IDX_W two-bit saturating counters indexed by pc[IDX_W+1:2].
REQ-019 SHALL drive pred_taken = if_is_branch AND BHT[if_pc idx][1], combinationally; pc_sel=01 when pred_taken, else 00, absent redirect.
REQ-020 SHALL resolve actual outcome: 000 beq taken=ex_zero; 001 bne taken=~ex_zero; 100 blt taken=~ex_pos&~ex_zero; 101 bge taken=ex_pos|ex_zero.
REQ-021 SHALL treat other funct3 (010,011,110,111) as not-taken, no BHT update, no counter update, no mispredict.
REQ-022 SHALL resolve only when FSM=IDLE, ex_branch=1, stall=0, funct3 valid ("resolve cycle").
REQ-023 SHALL on resolve cycle update BHT[ex_pc idx]: taken increments saturating at 11, not-taken decrements saturating at 00.
REQ-024 SHALL flag mispredict on resolve cycle when actual != ex_pred_taken.
REQ-025 SHALL on mispredict, same cycle: pc_sel=10, flush_ifid=1, flush_idex=1, redirect_pc = ex_target if taken else ex_pc+4 (XLEN modulo wrap).
REQ-026 SHALL implement FSM IDLE/RECOVER: IDLE->RECOVER on mispredict; RECOVER->IDLE on first cycle with stall=0; RECOVER holds while stall=1.
REQ-027 SHALL in RECOVER ignore ex_branch (squashed slot): no resolve, no update, no flush; IF prediction stays active.
REQ-028 SHALL with stall=1 force pc_sel=00, flushes=0, no BHT/counter/FSM change; resolution deferred until stall drops.
REQ-029 SHALL on same-index IF read and EX write in one cycle return pre-update value (no bypass).
REQ-030 SHALL redirect take priority over pred_taken for pc_sel.
REQ-031 SHALL increment branch_cnt per resolve cycle and mispred_cnt per mispredict, each saturating at 32'hFFFFFFFF.
REQ-032 SHALL register no output other than counters; redirect/flush latency from EX flags is zero cycles.

Reset
REQ-033 SHALL on reset=1 at clock edge set all BHT entries to 01, FSM to IDLE, both counters to 0.
REQ-034 SHALL while reset=1 force pred_taken=0, pc_sel=00, flushes=0, redirect_pc=0.
REQ-035 SHALL on reset in RECOVER return to IDLE with no pending flush.

Verification
REQ-036 Reset, then if_is_branch=1 any pc -> pred_taken=0, pc_sel=00, counters 0.
REQ-037 Beq ex_pc=0x100, ex_target=0x180, ex_zero=1, ex_pred_taken=0 -> pc_sel=10, redirect_pc=0x180, both flushes 1, mispred_cnt=1, BHT[0]=10, next cycle RECOVER ignores ex_branch=1.
REQ-038 Three taken bne at pc 0x40 with matching predictions -> BHT[0]=11 (saturates), no flush, branch_cnt=3; if_pc=0x40 -> pred_taken=1, pc_sel=01.
REQ-039 Bge mispredict (pred 1, pos=0, zero=0) ex_pc=0xFFFF_FFFF_FFFF_FFFC -> redirect_pc=0 (wrap).
REQ-040 Mispredicting blt with stall=1 for 2 cycles -> no flush/updates during stall; redirect on first stall=0 cycle.
REQ-041 funct3=010 with ex_branch=1 -> no flush, counters unchanged; reset asserted during RECOVER -> IDLE, outputs zero.
